// File: rtl/aes_core.sv
// Iterative AES-128/192/256 encryption engine. It expands one key word per cycle,
// then runs one cipher round per cycle and holds the result behind a level done flag.
module aes_core #(
    parameter int KEY_SIZE = 128
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic [127:0]        iPlaintext,
    input  logic [KEY_SIZE-1:0] iKey,
    output logic [127:0]        oCiphertext,
    output logic                oDone
);

    localparam int NK = KEY_SIZE / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
        $error("aes_core: KEY_SIZE must be 128, 192 or 256");
    end

    // Forward S-box, entry 0x00 in the top byte
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

    state_t       fsm_r;
    logic [31:0]  w_r [0:NW-1];
    logic [127:0] state_r;
    logic [5:0]   i_r;
    logic [2:0]   pos_r;
    logic [7:0]   rcon_r;
    logic [3:0]   rnd_r;
    logic         start_ok_s;
    logic [31:0]  temp_s;
    logic [31:0]  wnew_s;
    logic [127:0] sr_s;
    logic [127:0] mixed_s;
    logic [127:0] rnd_out_s;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte n of the state sits at bits [127-8n -: 8]; byte n is row n%4, column n/4
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] res;
        res = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    assign start_ok_s = !iRst && iStart && (fsm_r == IDLE || fsm_r == DONE);

    // Next expanded key word w[i] from w[i-1] and w[i-Nk]
    always_comb begin
        temp_s = w_r[i_r - 6'd1];
        if (pos_r == 3'd0) begin
            temp_s = sub_word({temp_s[23:0], temp_s[31:24]}) ^ {rcon_r, 24'h000000};
        end else if (NK == 8 && pos_r == 3'd4) begin
            temp_s = sub_word(temp_s);
        end else begin
            temp_s = w_r[i_r - 6'd1];
        end
        wnew_s = w_r[i_r - 6'(NK)] ^ temp_s;
    end

    // One cipher round on the current state; the final round skips MixColumns
    always_comb begin
        sr_s = sub_shift(state_r);
        if (rnd_r == 4'(NR)) begin
            mixed_s = sr_s;
        end else begin
            mixed_s = mix_columns(sr_s);
        end
        rnd_out_s = mixed_s ^ {w_r[{rnd_r, 2'b00}], w_r[{rnd_r, 2'b01}],
                               w_r[{rnd_r, 2'b10}], w_r[{rnd_r, 2'b11}]};
    end

    // Key schedule storage: key words on an accepted start, one new word per KEYEXP cycle
    always_ff @(posedge iClk) begin
        if (start_ok_s) begin
            for (int n = 0; n < NK; n++) begin
                w_r[n] <= iKey[KEY_SIZE - 1 - 32*n -: 32];
            end
        end else if (fsm_r == KEYEXP) begin
            w_r[i_r] <= wnew_s;
        end
    end

    // Control FSM with registered result and done flag
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fsm_r       <= IDLE;
            state_r     <= 128'd0;
            i_r         <= 6'd0;
            pos_r       <= 3'd0;
            rcon_r      <= 8'h00;
            rnd_r       <= 4'd0;
            oCiphertext <= 128'd0;
            oDone       <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE, DONE: begin
                    if (iStart) begin
                        state_r <= iPlaintext;
                        i_r     <= 6'(NK);
                        pos_r   <= 3'd0;
                        rcon_r  <= 8'h01;
                        oDone   <= 1'b0;
                        fsm_r   <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    i_r   <= i_r + 6'd1;
                    pos_r <= (pos_r == 3'(NK - 1)) ? 3'd0 : pos_r + 3'd1;
                    if (pos_r == 3'd0) begin
                        rcon_r <= xtime(rcon_r);
                    end
                    if (i_r == 6'(NW - 1)) begin
                        state_r <= state_r ^ {w_r[0], w_r[1], w_r[2], w_r[3]};
                        rnd_r   <= 4'd1;
                        fsm_r   <= ROUND;
                    end
                end
                ROUND: begin
                    state_r <= rnd_out_s;
                    if (rnd_r == 4'(NR)) begin
                        oCiphertext <= rnd_out_s;
                        oDone       <= 1'b1;
                        fsm_r       <= DONE;
                    end else begin
                        rnd_r <= rnd_r + 4'd1;
                    end
                end
                default: begin
                    fsm_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core.sv
// Directed known-answer bench for aes_core: one instance per key size, checking
// latency, ciphertext, hold behaviour, back-to-back starts and mid-operation events.
module tb_aes_core;

    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [191:0] K192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K128_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam int LIMIT = 200;

    logic         clk;
    logic         rst;
    logic [2:0]   start_v;
    logic [2:0]   done_v;
    logic [127:0] pt0, pt1, pt2;
    logic [127:0] ct0, ct1, ct2;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    int           n_checks;
    int           n_errors;

    aes_core #(.KEY_SIZE(128)) u_aes128 (
        .iClk(clk), .iRst(rst), .iStart(start_v[0]), .iPlaintext(pt0),
        .iKey(key128), .oCiphertext(ct0), .oDone(done_v[0])
    );

    aes_core #(.KEY_SIZE(192)) u_aes192 (
        .iClk(clk), .iRst(rst), .iStart(start_v[1]), .iPlaintext(pt1),
        .iKey(key192), .oCiphertext(ct1), .oDone(done_v[1])
    );

    aes_core #(.KEY_SIZE(256)) u_aes256 (
        .iClk(clk), .iRst(rst), .iStart(start_v[2]), .iPlaintext(pt2),
        .iKey(key256), .oCiphertext(ct2), .oDone(done_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: pulse start over one rising edge, then scramble that DUT's inputs
    task automatic start_op(input int sel);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        case (sel)
            0: begin pt0 = {4{$urandom}}; key128 = {4{$urandom}}; end
            1: begin pt1 = {4{$urandom}}; key192 = {6{$urandom}}; end
            default: begin pt2 = {4{$urandom}}; key256 = {8{$urandom}}; end
        endcase
        check_eq("done_low_after_start", 128'(done_v[sel]), 128'd0);
    endtask

    // Count rising edges after the start edge until done; optionally re-pulse start on DUT 0
    task automatic wait_done(input int sel, input int inj, output int cycles);
        cycles = 0;
        while (cycles < LIMIT) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (sel == 0 && cycles == inj) begin
                start_v[0] = 1'b1;
                pt0        = PT_B;
                key128     = K128_B;
            end else if (sel == 0 && cycles == inj + 1) begin
                start_v[0] = 1'b0;
            end
            if (done_v[sel]) break;
        end
    endtask

    initial begin
        int cyc;
        int highs;
        int stable_bad;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start_v  = 3'b000;
        pt0 = PT_A; pt1 = PT_A; pt2 = PT_A;
        key128 = K128_A; key192 = K192; key256 = K256;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_done128", 128'(done_v[0]), 128'd0);
        check_eq("rst_ct128", ct0, 128'd0);
        check_eq("rst_done192", 128'(done_v[1]), 128'd0);
        check_eq("rst_ct192", ct1, 128'd0);
        check_eq("rst_done256", 128'(done_v[2]), 128'd0);
        check_eq("rst_ct256", ct2, 128'd0);

        // AES-192 with a long idle hold afterwards
        start_op(1);
        wait_done(1, -1, cyc);
        check_eq("lat192", 128'(cyc), 128'd58);
        check_eq("ct192", ct1, CT192);
        stable_bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_v[1] !== 1'b1 || ct1 !== CT192) stable_bad++;
        end
        check_eq("hold192", 128'(stable_bad), 128'd0);

        // AES-256
        start_op(2);
        wait_done(2, -1, cyc);
        check_eq("lat256", 128'(cyc), 128'd66);
        check_eq("ct256", ct2, CT256);

        // AES-128 first vector
        start_op(0);
        wait_done(0, -1, cyc);
        check_eq("lat128_a", 128'(cyc), 128'd50);
        check_eq("ct128_a", ct0, CT128);

        // Back-to-back start straight from DONE
        pt0 = PT_B; key128 = K128_B;
        start_op(0);
        check_eq("b2b_ct_hold", ct0, CT128);
        wait_done(0, -1, cyc);
        check_eq("lat128_b2b", 128'(cyc), 128'd50);
        check_eq("ct128_b2b", ct0, CT_B);

        // Start pulse with new inputs during ROUND must not disturb the run
        pt0 = PT_A; key128 = K128_A;
        start_op(0);
        wait_done(0, 45, cyc);
        check_eq("lat128_midstart", 128'(cyc), 128'd50);
        check_eq("ct128_midstart", ct0, CT128);
        repeat (3) @(negedge clk);
        check_eq("midstart_still_done", 128'(done_v[0]), 128'd1);

        // Reset during KEYEXP aborts; a fresh start then works
        pt0 = PT_B; key128 = K128_B;
        start_op(0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_done", 128'(done_v[0]), 128'd0);
        check_eq("abort_ct", ct0, 128'd0);
        highs = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0) highs++;
        end
        check_eq("abort_no_done", 128'(highs), 128'd0);
        pt0 = PT_B; key128 = K128_B;
        start_op(0);
        wait_done(0, -1, cyc);
        check_eq("lat128_after_abort", 128'(cyc), 128'd50);
        check_eq("ct128_after_abort", ct0, CT_B);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_core.md
# aes_core

Iterative AES encryption engine (FIPS-197) for 128-, 192- or 256-bit keys, selected at elaboration by a parameter. One start pulse launches key expansion followed by one cipher round per clock. It signals completion with a level `oDone` and holds the ciphertext until the next accepted start. Encrypt only; it sits under the top-level crypto wrapper, which supplies a plaintext block and key per request.

## Interface
- `KEY_SIZE`, default 128: key length in bits, one of 128/192/256. Derived values: Nk = KEY_SIZE/32 (4/6/8), Nr = Nk+6 (10/12/14). Any other value is an elaboration error.
- `iClk` input 1: single clock, all logic on rising edge.
- `iRst` input 1: reset, synchronous, active-high.
- `iStart` input 1: start request, sampled each edge.
- `iPlaintext` input 128: plaintext block. Bits [127:120] are state byte 0; bytes fill the state column-major.
- `iKey` input KEY_SIZE: cipher key. Top 32 bits are w[0], next 32 are w[1], and so on.
- `oCiphertext` output 128: ciphertext, same byte order as `iPlaintext`.
- `oDone` output 1: result valid (level).

## Operation
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- IDLE or DONE with `iStart`=1:
  - latch `iPlaintext` and `iKey`; load w[0..Nk-1] from the key; set word counter i=Nk;
  - clear `oDone`; go to KEYEXP.
- KEYEXP: compute one word per cycle and store w[i] into a 4*(Nr+1)-entry word array (max 60 words):
  - temp=w[i-1];
  - if i mod Nk==0: temp=SubWord(RotWord(temp))^Rcon[i/Nk], with Rcon = 01,02,04,08,10,20,40,80,1b,36 in the MSB byte;
  - else if Nk==8 and i mod Nk==4: temp=SubWord(temp);
  - w[i]=w[i-Nk]^temp.
  - On the cycle w[4Nr+3] is written: state = plaintext ^ {w0,w1,w2,w3}, round r=1, go to ROUND.
- ROUND: each cycle state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), w[4r..4r+3]).
  - MixColumns is omitted when r==Nr.
  - r increments; after round Nr, load `oCiphertext` with the result, set `oDone`=1, go to DONE.
- DONE: hold `oCiphertext` and `oDone`=1 until an accepted `iStart` or reset.
- `iStart` during KEYEXP or ROUND is ignored; the operation in flight is not disturbed.
- Plaintext and key inputs may change after the start edge without effect.
- S-box: combinational FIPS-197 table. 16 instances in the datapath and 4 in key expansion are permitted.
- MixColumns uses GF(2^8) xtime with the 0x1b reduction.

## Timing
- Reset (`iRst`=1 at an edge): FSM to IDLE, `oDone`=0, `oCiphertext`=0, counters cleared.
  - Reset overrides `iStart` on the same edge.
  - Reset mid-operation aborts the operation; no done is produced.
- KEYEXP length is 4(Nr+1)-Nk cycles: 40/46/52.
- Latency: with `iStart` sampled at edge E0, `oDone` rises and `oCiphertext` is valid at edge E0+N_ke+Nr, i.e. E0+50 (AES-128), E0+58 (AES-192), E0+66 (AES-256).
- `oDone` falls at the edge that accepts the next `iStart`. `oCiphertext` keeps its old value until the new result is loaded.
- Back-to-back: a start accepted in DONE begins a new operation with identical latency.

## Test plan
- AES-128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, `oDone` exactly 50 cycles after the start edge.
- AES-192 (KEY_SIZE=192), key 000102030405060708090a0b0c0d0e0f1011121314151617, same pt -> ct dda97ca4864cdfe06eaf70a0ec0d7191 at 58 cycles; `oDone` stays high and ct stays stable for 20+ idle cycles.
- AES-256, key 000102…1e1f, same pt -> ct 8ea2b7ca516745bfeafc49904b496089 at 66 cycles.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
  - Back-to-back from DONE: start the second vector immediately; `oDone` drops on the next edge, and the second ct appears at the second start edge +50.
- Mid-operation events:
  - Pulse `iStart` and change pt/key during ROUND -> the first result is unaffected.
  - Assert `iRst` during KEYEXP -> `oDone`=0 and `oCiphertext`=0 on the next edge, no done until a new start, and a new start yields a correct result.
